// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-requester SPI bus arbiter: requester count,
// default parameter values, the controller state encoding and a small helper
// telling whether a state owns the bus.
package spi_arb_pkg;

  localparam int NREQ             = 2;
  localparam int CSW              = 3;    // chip-select index width
  localparam int DW               = 8;    // byte width
  localparam int NCS_DEFAULT      = 4;
  localparam int GAP_DEFAULT      = 2;
  localparam int HOLD_MAX_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_HOLD = 3'd2,
    ST_XFER = 3'd3,
    ST_GAP  = 3'd4
  } arb_state_e;

  // GNT and the selected SS_N are active exactly in these states.
  function automatic logic in_txn(arb_state_e s);
    return (s == ST_SEL) || (s == ST_HOLD) || (s == ST_XFER);
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the byte-level SPI
// engine.
//   master : requester/engine side (drives req/cssel/txd/valid/last and the
//            engine status e_busy/e_done/e_rxd)
//   slave  : the arbiter (drives grants, handshakes, receive data, engine
//            start/byte and the chip selects)
interface spi_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NCS = NCS_DEFAULT
);
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][CSW-1:0] cssel;
  logic [NREQ-1:0][DW-1:0]  txd;
  logic [NREQ-1:0]          valid;
  logic [NREQ-1:0]          last;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          ready;
  logic [DW-1:0]            rxd;
  logic [NREQ-1:0]          rxv;
  logic [NREQ-1:0]          err;
  logic                     e_start;
  logic [DW-1:0]            e_txd;
  logic                     e_busy;
  logic                     e_done;
  logic [DW-1:0]            e_rxd;
  logic [NCS-1:0]           ss_n;

  modport master (
    output req, cssel, txd, valid, last, e_busy, e_done, e_rxd,
    input  gnt, ready, rxd, rxv, err, e_start, e_txd, ss_n
  );

  modport slave (
    input  req, cssel, txd, valid, last, e_busy, e_done, e_rxd,
    output gnt, ready, rxd, rxv, err, e_start, e_txd, ss_n
  );

endinterface

// File: rtl/spi_arbiter_rr_pick2.sv
// Two-way round-robin pick.
//   req_i  : pending requests
//   last_i : index of the requester granted most recently
//   pick_o : one-hot winner, zero when nothing is requested
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = 2'b00;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = last_i ? 2'b01 : 2'b10;
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates two requesters onto one byte-level SPI engine and drives the
// chip selects.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : requester handshakes, engine start/status, SS_N
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, SS_N high; arbitrate pending requests
// SEL   | owner granted, chip select asserted, one cycle of CS setup
// HOLD  | waiting for the owner to offer a byte (READY when engine idle)
// XFER  | engine shifting a byte; wait for E_DONE
// GAP   | all SS_N high for GAP cycles, requests not looked at
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NCS      = NCS_DEFAULT,
  parameter int GAP      = GAP_DEFAULT,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input logic          clk_i,
  input logic          rst_i,
  spi_arbiter_if.slave bus
);

  localparam int HCW = $clog2(HOLD_MAX + 1);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [CSW-1:0]      cs_q, cs_d;
  logic                last_gnt_q, last_gnt_d;
  logic                tlast_q, tlast_d;
  logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GCW-1:0]      gap_cnt_q, gap_cnt_d;
  logic                e_start_q, e_start_d;
  logic [DW-1:0]       e_txd_q, e_txd_d;
  logic [DW-1:0]       rxd_q, rxd_d;
  logic [NREQ-1:0]     rxv_q, rxv_d;
  logic [NREQ-1:0]     err_q, err_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NCS-1:0]      ss_n_q, ss_n_d;
  logic [NREQ-1:0]     pick;
  logic [NREQ-1:0]     ready;
  logic                accept;

  rr_pick2 u_pick (
    .req_i  (bus.req),
    .last_i (last_gnt_q),
    .pick_o (pick)
  );

  assign ready  = (state_q == ST_HOLD && !bus.e_busy) ? gnt_q : '0;
  assign accept = bus.valid[owner_q] & ready[owner_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cs_d       = cs_q;
    last_gnt_d = last_gnt_q;
    tlast_d    = tlast_q;
    hold_cnt_d = '0;
    gap_cnt_d  = gap_cnt_q;
    e_start_d  = 1'b0;
    e_txd_d    = e_txd_q;
    rxd_d      = rxd_q;
    rxv_d      = '0;
    err_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          owner_d    = pick[1];
          last_gnt_d = pick[1];
          cs_d       = bus.cssel[pick[1]];
          state_d    = ST_SEL;
        end
      end
      ST_SEL: state_d = ST_HOLD;
      ST_HOLD: begin
        // An offered byte wins over a simultaneous request drop so a READY
        // that was shown is always honoured; XFER then closes the transaction.
        if (accept) begin
          e_start_d = 1'b1;
          e_txd_d   = bus.txd[owner_q];
          tlast_d   = bus.last[owner_q];
          state_d   = ST_XFER;
        end else if (!bus.req[owner_q]) begin
          gap_cnt_d = GCW'(GAP - 1);
          state_d   = ST_GAP;
        end else if (hold_cnt_q >= HCW'(HOLD_MAX - 1)) begin
          err_d[owner_q] = 1'b1;
          gap_cnt_d      = GCW'(GAP - 1);
          state_d        = ST_GAP;
        end else if (hold_cnt_q != HCW'(HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      ST_XFER: begin
        if (bus.e_done) begin
          rxd_d          = bus.e_rxd;
          rxv_d[owner_q] = 1'b1;
          if (tlast_q || !bus.req[owner_q]) begin
            gap_cnt_d = GCW'(GAP - 1);
            state_d   = ST_GAP;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant and chip selects are registered from the next state so they switch
  // glitch-free and on the same edge as the state itself.
  always_comb begin
    gnt_d  = '0;
    ss_n_d = '1;
    if (in_txn(state_d)) gnt_d = owner_d ? 2'b10 : 2'b01;
    // An out-of-range index matches no bit: granted, but no device selected.
    for (int i = 0; i < NCS; i++) begin
      if (in_txn(state_d) && cs_d == CSW'(i)) ss_n_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      cs_q       <= '0;
      last_gnt_q <= 1'b1;   // so requester 0 wins the first tie
      tlast_q    <= 1'b0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      e_start_q  <= 1'b0;
      e_txd_q    <= '0;
      rxd_q      <= '0;
      rxv_q      <= '0;
      err_q      <= '0;
      gnt_q      <= '0;
      ss_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cs_q       <= cs_d;
      last_gnt_q <= last_gnt_d;
      tlast_q    <= tlast_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      e_start_q  <= e_start_d;
      e_txd_q    <= e_txd_d;
      rxd_q      <= rxd_d;
      rxv_q      <= rxv_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ready   = ready;
  assign bus.rxd     = rxd_q;
  assign bus.rxv     = rxv_q;
  assign bus.err     = err_q;
  assign bus.e_start = e_start_q;
  assign bus.e_txd   = e_txd_q;
  assign bus.ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: a behavioural SPI engine, a receive
// scoreboard, a table of single-byte transactions and hand-written sequences.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int NCS_TB  = 4;
  localparam int GAP_TB  = 2;
  localparam int HOLD_TB = 255;
  localparam int ENG_LAT = 3;

  logic clk;
  logic rst;

  spi_arbiter_if #(.NCS(NCS_TB)) bus ();

  spi_arbiter #(
    .NCS      (NCS_TB),
    .GAP      (GAP_TB),
    .HOLD_MAX (HOLD_TB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_starts = 0;
  int         done_cyc = 0;
  int         err_cnt  = 0;
  logic       b2b_chk  = 1'b0;
  logic       stray    = 1'b0;
  logic [3:0] mon_ss   = 4'hF;
  logic [7:0] txq[$];
  logic [9:0] rxq[$];
  logic [9:0] exp_rx;

  typedef struct {
    logic [1:0] req;
    logic [2:0] c0;
    logic [2:0] c1;
    logic [1:0] gnt;
    logic [3:0] ss;
  } vec_t;
  vec_t tbl[9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail_msg(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_fail++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) fail_msg(name, act, exp);
  endtask

  // Behavioural engine: busy for ENG_LAT cycles after E_START, then a one-cycle
  // E_DONE with the sent byte XOR 5A as the received byte.
  initial begin
    int         cnt;
    logic [7:0] cur;
    cnt = 0;
    cur = '0;
    bus.e_busy = 1'b0;
    bus.e_done = 1'b0;
    bus.e_rxd  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.e_done = 1'b0;
      if (rst) begin
        bus.e_busy = 1'b0;
        cnt = 0;
      end else if (stray) begin
        bus.e_done = 1'b1;
        bus.e_rxd  = 8'hEE;
        stray = 1'b0;
      end else if (bus.e_start) begin
        n_starts++;
        if (b2b_chk) chk("b2b_idle", cyc - done_cyc, 2);
        if (txq.size() == 0) fail_msg("e_start_unexpected", bus.e_txd, 0);
        else chk("e_txd", bus.e_txd, txq.pop_front());
        cur = bus.e_txd;
        bus.e_busy = 1'b1;
        cnt = ENG_LAT;
      end else if (bus.e_busy) begin
        if (bus.e_txd !== cur) fail_msg("e_txd_stable", bus.e_txd, cur);
        cnt--;
        if (cnt == 0) begin
          bus.e_busy = 1'b0;
          bus.e_done = 1'b1;
          bus.e_rxd  = cur ^ 8'h5A;
          done_cyc   = cyc;
        end
      end
    end
  end

  // Monitor: invariants every cycle, receive scoreboard on RXV.
  always @(negedge clk) begin
    if (bus.gnt == 2'b11) fail_msg("gnt_onehot", bus.gnt, 2'b01);
    if (bus.gnt != 2'b00 && bus.ss_n !== mon_ss) fail_msg("ss_n_granted", bus.ss_n, mon_ss);
    if (bus.gnt == 2'b00 && bus.ss_n !== 4'hF) fail_msg("ss_n_idle", bus.ss_n, 4'hF);
    if (bus.err != 2'b00) err_cnt++;
    if (bus.rxv != 2'b00) begin
      if (rxq.size() == 0) fail_msg("rxv_unexpected", {bus.rxv, bus.rxd}, 0);
      else begin
        exp_rx = rxq.pop_front();
        chk("rxv_rxd", {bus.rxv, bus.rxd}, exp_rx);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // One transaction of nb (1 or 2) bytes; the other requester offers a byte
  // at the same time, which must never be accepted.
  task automatic run_txn(input logic [1:0] req_m, input logic [2:0] c0, input logic [2:0] c1,
                         input int nb, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [1:0] exp_g, input logic [3:0] exp_ss, input string tag);
    int         g;
    int         t;
    logic [7:0] d;
    bus.req      = req_m;
    bus.cssel[0] = c0;
    bus.cssel[1] = c1;
    mon_ss       = exp_ss;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt == 2'b00 && t < 20);
    chk({tag, "_gnt"}, bus.gnt, exp_g);
    chk({tag, "_ss"}, bus.ss_n, exp_ss);
    g = bus.gnt[1] ? 1 : 0;
    for (int i = 0; i < nb; i++) begin
      d = (i == 0) ? b0 : b1;
      bus.txd[g]     = d;
      bus.last[g]    = (i == nb - 1);
      bus.valid[g]   = 1'b1;
      bus.txd[1-g]   = ~d;
      bus.last[1-g]  = 1'b1;
      bus.valid[1-g] = 1'b1;
      b2b_chk = (i > 0);
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.ready[g] && t < 40);
      chk({tag, "_ready"}, bus.ready[g], 1'b1);
      chk({tag, "_ready_other"}, bus.ready[1-g], 1'b0);
      txq.push_back(d);
      rxq.push_back({(g == 1) ? 2'b10 : 2'b01, d ^ 8'h5A});
      @(posedge clk);
      #1;
      bus.valid = '0;
    end
    b2b_chk = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt != 2'b00 && t < 60);
    chk({tag, "_release"}, bus.gnt, 2'b00);
    @(negedge clk);
    chk({tag, "_rx_done"}, rxq.size(), 0);
    bus.last = '0;
  endtask

  initial begin
    int         t;
    int         s0;
    int         low;
    rst       = 1'b1;
    bus.req   = '0;
    bus.cssel = '0;
    bus.txd   = '0;
    bus.valid = '0;
    bus.last  = '0;

    tbl[0] = '{2'b11, 3'd2, 3'd1, 2'b01, 4'b1011};
    tbl[1] = '{2'b11, 3'd2, 3'd1, 2'b10, 4'b1101};
    tbl[2] = '{2'b11, 3'd2, 3'd1, 2'b01, 4'b1011};
    tbl[3] = '{2'b11, 3'd2, 3'd1, 2'b10, 4'b1101};
    tbl[4] = '{2'b01, 3'd0, 3'd1, 2'b01, 4'b1110};
    tbl[5] = '{2'b01, 3'd5, 3'd1, 2'b01, 4'b1111};
    tbl[6] = '{2'b10, 3'd0, 3'd3, 2'b10, 4'b0111};
    tbl[7] = '{2'b11, 3'd7, 3'd0, 2'b01, 4'b1111};
    tbl[8] = '{2'b11, 3'd7, 3'd0, 2'b10, 4'b1110};

    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_ready", bus.ready, 2'b00);
    chk("rst_rxv", bus.rxv, 2'b00);
    chk("rst_err", bus.err, 2'b00);
    chk("rst_e_start", bus.e_start, 1'b0);
    chk("rst_e_txd", bus.e_txd, 8'h00);
    chk("rst_rxd", bus.rxd, 8'h00);
    chk("rst_ss_n", bus.ss_n, 4'hF);
    rst = 1'b0;

    // Round-robin and chip-select decode, one single-byte transaction per row.
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].req, tbl[i].c0, tbl[i].c1, 1, 8'h10 + 8'(i), 8'h00,
              tbl[i].gnt, tbl[i].ss, $sformatf("tbl%0d", i));
    end
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Stray E_DONE while idle changes nothing.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_gnt", bus.gnt, 2'b00);
    chk("stray_rxd", bus.rxd, 8'h18 ^ 8'h5A);

    // Two-byte transaction on CS2, then measure the deselect window with the
    // request still high: GAP cycles plus the IDLE arbitration cycle.
    s0 = n_starts;
    run_txn(2'b01, 3'd2, 3'd0, 2, 8'hA5, 8'h3C, 2'b01, 4'b1011, "two_byte");
    chk("two_byte_starts", n_starts - s0, 2);
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt == 2'b00 && t < 20);
    low = 2 + t - 1;
    chk("gap_len", low, GAP_TB + 1);
    // Drop the request in SEL: HOLD sees it low and releases without ERR.
    bus.req = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt != 2'b00 && t < 10);
    chk("hold_drop", t, 2);

    // Request dropped one cycle after E_START: byte completes, then GAP.
    bus.req      = 2'b01;
    bus.cssel[0] = 3'd1;
    mon_ss       = 4'b1101;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt == 2'b00 && t < 20);
    chk("drop_gnt", bus.gnt, 2'b01);
    bus.txd[0]   = 8'h77;
    bus.last[0]  = 1'b0;
    bus.valid[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ready[0] && t < 20);
    chk("drop_ready", bus.ready[0], 1'b1);
    txq.push_back(8'h77);
    rxq.push_back({2'b01, 8'h77 ^ 8'h5A});
    @(posedge clk);
    #1;
    bus.valid = '0;
    @(posedge clk);
    #1;
    bus.req = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt != 2'b00 && t < 20);
    chk("drop_rxv_at_release", bus.rxv, 2'b01);
    chk("drop_rxd", bus.rxd, 8'h77 ^ 8'h5A);
    @(negedge clk);
    chk("drop_rx_done", rxq.size(), 0);

    // Hold timeout on requester 1: ERR one cycle after the 255th HOLD cycle.
    bus.req      = 2'b10;
    bus.cssel[1] = 3'd0;
    mon_ss       = 4'b1110;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt == 2'b00 && t < 20);
    chk("to_gnt", bus.gnt, 2'b10);
    t = 0;
    do begin @(negedge clk); t++; end while (bus.err == 2'b00 && t < 400);
    chk("to_cycles", t, HOLD_TB + 1);
    chk("to_err", bus.err, 2'b10);
    chk("to_gnt_off", bus.gnt, 2'b00);
    chk("to_ss_n", bus.ss_n, 4'hF);
    bus.req = '0;
    @(negedge clk);
    chk("to_err_pulse", bus.err, 2'b00);
    repeat (5) @(negedge clk);
    chk("to_idle", bus.gnt, 2'b00);

    // Reset in XFER aborts the byte with no RXV.
    bus.req      = 2'b10;
    bus.cssel[1] = 3'd2;
    mon_ss       = 4'b1011;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.gnt == 2'b00 && t < 20);
    chk("rx_gnt", bus.gnt, 2'b10);
    bus.txd[1]   = 8'h99;
    bus.last[1]  = 1'b1;
    bus.valid[1] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ready[1] && t < 20);
    chk("rx_ready", bus.ready[1], 1'b1);
    txq.push_back(8'h99);
    @(posedge clk);
    #1;
    bus.valid = '0;
    bus.last  = '0;
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rx_ss_n", bus.ss_n, 4'hF);
    chk("rx_gnt_off", bus.gnt, 2'b00);
    chk("rx_rxv", bus.rxv, 2'b00);
    repeat (6) @(negedge clk);
    run_txn(2'b11, 3'd3, 3'd1, 1, 8'h5C, 8'h00, 2'b01, 4'b0111, "post_rst_tie");
    run_txn(2'b10, 3'd3, 3'd1, 1, 8'hC3, 8'h00, 2'b10, 4'b1101, "post_rst_req1");
    bus.req = '0;
    repeat (4) @(negedge clk);

    chk("err_count", err_cnt, 1);
    chk("tx_queue_empty", txq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NCS, default 4: number of chip selects driven, 1..8.
REQ-002 Parameter GAP, default 2: minimum CLK cycles with all SS_N high between two transactions, at least 1.
REQ-003 Parameter HOLD_MAX, default 255: maximum idle cycles in HOLD before forced release.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 REQ  in  2  per-requester bus request; level, held for whole transaction.
REQ-008 CSSEL  in  2x3  per-requester chip-select index, sampled at grant.
REQ-009 TXD  in  2x8  per-requester byte to send.
REQ-010 VALID  in  2  per-requester byte-valid strobe.
REQ-011 LAST  in  2  per-requester flag, qualified by VALID: this byte ends the transaction.
REQ-012 GNT  out  2  one-hot grant; at most one bit high.
REQ-013 READY  out  2  byte accepted when VALID & READY on the same edge.
REQ-014 RXD  out  8  received byte, shared by both requesters.
REQ-015 RXV  out  2  one-cycle pulse to the granted requester when RXD is valid.
REQ-016 ERR  out  2  one-cycle pulse on forced release of that requester.
REQ-017 E_START  out  1  one-cycle start pulse to the byte-level SPI engine.
REQ-018 E_TXD  out  8  byte for the engine, stable from E_START until E_DONE.
REQ-019 E_BUSY  in  1  engine shifting.
REQ-020 E_DONE  in  1  one-cycle pulse from the engine, byte complete.
REQ-021 E_RXD  in  8  engine receive byte, valid with E_DONE.
REQ-022 SS_N  out  NCS  active-low chip selects; at most one bit low.

Function
REQ-023 The block SHALL implement five states: IDLE, SEL, HOLD, XFER, GAP.
REQ-024 IDLE: when any REQ is high, the block SHALL latch the winner and its CSSEL, go to SEL, and assert GNT and SS_N[cs] low on the next edge.
REQ-025 Arbitration SHALL be round-robin: on simultaneous REQ, the requester not granted most recently wins; after reset requester 0 wins.
REQ-026 SEL SHALL last exactly one cycle (CS setup), then go to HOLD.
REQ-027 In HOLD, READY SHALL equal GNT & !E_BUSY; on acceptance the block SHALL pulse E_START on the next edge, latch E_TXD and LAST, and go to XFER.
REQ-028 In XFER, READY SHALL be 0; on E_DONE, RXD SHALL take E_RXD and RXV[gnt] SHALL pulse on the next edge.
REQ-029 On E_DONE with LAST latched, the block SHALL go to GAP, deasserting GNT and all SS_N on the same edge.
REQ-030 On E_DONE without LAST, the block SHALL return to HOLD; back-to-back bytes SHALL give one idle cycle between E_DONE and the next E_START.
REQ-031 If REQ of the granted requester drops in HOLD, the block SHALL go to GAP next edge without ERR.
REQ-032 If REQ drops in XFER, the block SHALL complete the byte, deliver RXV, then go to GAP.
REQ-033 HOLD with no acceptance for HOLD_MAX consecutive cycles SHALL force GAP and pulse ERR[gnt]; the counter SHALL clear on every acceptance and SHALL saturate, not wrap.
REQ-034 GAP SHALL hold all SS_N high for exactly GAP cycles, then go to IDLE; requests are not evaluated during GAP.
REQ-035 CSSEL >= NCS SHALL be granted, but no SS_N SHALL go low.
REQ-036 VALID from a non-granted requester SHALL be ignored, with READY low.
REQ-037 E_DONE outside XFER SHALL be ignored.

Reset
REQ-038 On RST the block SHALL enter IDLE and set SS_N all ones, GNT/READY/RXV/ERR/E_START to 0, RXD/E_TXD to 0, the round-robin pointer to favour requester 0, and the hold counter to 0.
REQ-039 RST mid-XFER SHALL abort with no RXV; the engine shares RST.

Structure
REQ-040 The state enum, NREQ=2 and the default parameter values SHALL live in package spi_arb_pkg.
REQ-041 The round-robin choice SHALL be the sub-module rr_pick2 (inputs req[1:0], last; output one-hot pick).

Verification
REQ-042 REQ=01, CSSEL0=2, bytes A5,3C with LAST on 3C -> SS_N=1011 from SEL through the second E_DONE, two E_START pulses, RXV0 twice, then SS_N=1111 for 2 cycles.
REQ-043 REQ=11 asserted together after reset, single-byte transactions -> grant order 0,1,0,1; GNT never 11; GAP between each.
REQ-044 Grant requester 1 and hold REQ high with no VALID, HOLD_MAX=255 -> ERR1 pulse at cycle 255 of HOLD, SS_N all high, then IDLE.
REQ-045 REQ0 dropped one cycle after E_START -> byte completes, RXV0 pulses with RXD=E_RXD, GAP entered, no ERR.
REQ-046 RST asserted in XFER -> next edge SS_N=1111, GNT=00, no RXV; fresh REQ1 after reset is granted, with requester 0 favoured on a tie.
REQ-047 CSSEL=5 with NCS=4 -> GNT asserted, byte transferred, SS_N stays 1111 throughout.
